echo2distance_converter: RTL and testbench

Measures range with an HC-SR04-class ultrasonic sensor and produces a distance word in units of 10^-2 cm, saturated to a configurable maximum. It generates the trigger pulse, times the echo pulse, and presents each result with a one-cycle valid strobe. It sits directly upstream of the distance-to-PWM stage, whose `distance` input it drives.

---
 rtl/echo2distance_pkg.sv | 25 ++
 rtl/echo2distance_converter_if.sv | 22 ++
 rtl/echo2distance_converter_sync_2ff.sv | 24 ++
 rtl/echo2distance_converter.sv | 208 ++++++++++++++++++++
 tb/tb_echo2distance_converter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/echo2distance_pkg.sv
// rtl/echo2distance_pkg.sv - shared state type and default timing constants for the echo-to-distance converter
package echo2distance_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } e2d_state_t;

  // Defaults assume a 50 MHz clock and an HC-SR04-class sensor.
  localparam int DEF_WIDTH          = 13;
  localparam int DEF_CLKS_PER_UNIT  = 29;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_MAX_DISTANCE   = 4000;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEF_CYCLE_PERIOD   = 3_000_000;

  // Bits needed for a counter that must hold values 0..max_value.
  function automatic int cnt_bits(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/echo2distance_converter_if.sv
// rtl/echo2distance_converter_if.sv - result bus from the converter to the distance-to-PWM stage
interface echo2distance_converter_if #(
  parameter int WIDTH = 13
);

  logic [WIDTH-1:0] distance;
  logic             distance_valid;
  logic             out_of_range;

  modport master (
    output distance,
    output distance_valid,
    output out_of_range
  );

  modport slave (
    input distance,
    input distance_valid,
    input out_of_range
  );

endinterface

// File: rtl/echo2distance_converter_sync_2ff.sv
// rtl/echo2distance_converter_sync_2ff.sv - generic two-flop synchronizer, resets to 0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/echo2distance_converter.sv
// rtl/echo2distance_converter.sv - ultrasonic trigger/echo timer producing distance in 0.01 cm; ECHO2DIST_AVG_EN enables 4-result averaging
module echo2distance_converter
  import echo2distance_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int CLKS_PER_UNIT  = DEF_CLKS_PER_UNIT,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int MAX_DISTANCE   = DEF_MAX_DISTANCE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYCLE_PERIOD   = DEF_CYCLE_PERIOD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       echo,
  output logic                       trig,
  echo2distance_converter_if.master  res
);

  localparam int PW = cnt_bits(CYCLE_PERIOD - 1);
  localparam int TW = cnt_bits(TRIG_CYCLES - 1);
  localparam int OW = cnt_bits(TIMEOUT_CYCLES);
  localparam int SW = cnt_bits(CLKS_PER_UNIT - 1);

  localparam logic [PW-1:0]    PERIOD_LAST = PW'(CYCLE_PERIOD - 1);
  localparam logic [TW-1:0]    TRIG_LAST   = TW'(TRIG_CYCLES - 1);
  localparam logic [OW-1:0]    TIMEOUT_LIM = OW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]    PRESC_LAST  = SW'(CLKS_PER_UNIT - 1);
  localparam logic [WIDTH-1:0] MAX_D       = WIDTH'(MAX_DISTANCE);

  // The cycle that reveals the rising edge is already an echo-high cycle,
  // so the measurement starts with that cycle counted.
  localparam logic [SW-1:0]    PRESC_FIRST = (CLKS_PER_UNIT == 1) ? '0 : SW'(1);
  localparam logic [WIDTH-1:0] UNIT_FIRST  =
    (CLKS_PER_UNIT == 1 && MAX_DISTANCE > 0) ? WIDTH'(1) : '0;

  e2d_state_t       state;
  logic [PW-1:0]    period_cnt;
  logic [TW-1:0]    trig_cnt;
  logic [OW-1:0]    timeout_cnt;
  logic [SW-1:0]    presc;
  logic [WIDTH-1:0] unit_cnt;

  logic             echo_s;
  logic             echo_d;
  logic             echo_rise;
  logic             echo_fall;

  logic             finish;
  logic             fin_oor;
  logic [WIDTH-1:0] fin_val;
  logic [WIDTH-1:0] report_val;

  sync_2ff #(
    .WIDTH (1)
  ) u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  // One-cycle delay of the synchronized echo for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_d <= 1'b0;
    end else begin
      echo_d <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

  // Decide whether this cycle ends a measurement and with what raw result;
  // timeout wins over a coincident falling edge.
  always_comb begin
    finish  = 1'b0;
    fin_val = MAX_D;
    fin_oor = 1'b1;
    if ((state == WAIT_ECHO || state == MEASURE) && timeout_cnt == TIMEOUT_LIM) begin
      finish = 1'b1;
    end else if (state == MEASURE && echo_fall) begin
      finish  = 1'b1;
      fin_val = unit_cnt;
      fin_oor = (unit_cnt == MAX_D);
    end
  end

`ifdef ECHO2DIST_AVG_EN
  // The incoming result plus the three previous ones form the 4-entry history.
  logic [WIDTH-1:0] hist [3];
  logic             hist_full;
  logic [WIDTH+1:0] avg_sum;

  // Running sum of the 4-entry history; the first result counts four times.
  always_comb begin
    avg_sum = '0;
    if (hist_full) begin
      avg_sum = (WIDTH+2)'(fin_val) + (WIDTH+2)'(hist[0])
              + (WIDTH+2)'(hist[1]) + (WIDTH+2)'(hist[2]);
    end else begin
      avg_sum = {fin_val, 2'b00};
    end
  end

  assign report_val = avg_sum[WIDTH+1:2];

  // Shift each finished result into the history, filling it on the first one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist[0]   <= '0;
      hist[1]   <= '0;
      hist[2]   <= '0;
      hist_full <= 1'b0;
    end else if (finish) begin
      hist[0]   <= fin_val;
      hist[1]   <= hist_full ? hist[0] : fin_val;
      hist[2]   <= hist_full ? hist[1] : fin_val;
      hist_full <= 1'b1;
    end
  end
`else
  assign report_val = fin_val;
`endif

  // Measurement sequencer: trigger, wait for echo, time it, publish result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      trig               <= 1'b0;
      period_cnt         <= PERIOD_LAST;
      trig_cnt           <= '0;
      timeout_cnt        <= '0;
      presc              <= '0;
      unit_cnt           <= '0;
      res.distance       <= '0;
      res.distance_valid <= 1'b0;
      res.out_of_range   <= 1'b0;
    end else begin
      res.distance_valid <= 1'b0;
      if (period_cnt != PERIOD_LAST) begin
        period_cnt <= period_cnt + 1'b1;
      end

      if (finish) begin
        state              <= DONE;
        res.distance       <= report_val;
        res.out_of_range   <= fin_oor;
        res.distance_valid <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (enable && period_cnt == PERIOD_LAST) begin
              state      <= TRIG;
              trig       <= 1'b1;
              trig_cnt   <= '0;
              period_cnt <= '0;
            end
          end

          TRIG: begin
            if (trig_cnt == TRIG_LAST) begin
              state       <= WAIT_ECHO;
              trig        <= 1'b0;
              timeout_cnt <= '0;
            end else begin
              trig_cnt <= trig_cnt + 1'b1;
            end
          end

          WAIT_ECHO: begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (echo_rise) begin
              state    <= MEASURE;
              presc    <= PRESC_FIRST;
              unit_cnt <= UNIT_FIRST;
            end
          end

          MEASURE: begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (echo_s) begin
              if (presc == PRESC_LAST) begin
                presc <= '0;
                if (unit_cnt != MAX_D) begin
                  unit_cnt <= unit_cnt + 1'b1;
                end
              end else begin
                presc <= presc + 1'b1;
              end
            end
          end

          DONE: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
            trig  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_echo2distance_converter.sv
// tb/tb_echo2distance_converter.sv - self-checking bench for echo2distance_converter with scaled timing
module tb_echo2distance_converter;

  localparam int WIDTH = 13;
  localparam int CPU   = 5;
  localparam int TRIGC = 10;
  localparam int MAXD  = 100;
  localparam int TMO   = 800;
  localparam int CP    = 1000;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic echo;
  logic trig;

  echo2distance_converter_if #(.WIDTH(WIDTH)) bus ();

  echo2distance_converter #(
    .WIDTH          (WIDTH),
    .CLKS_PER_UNIT  (CPU),
    .TRIG_CYCLES    (TRIGC),
    .MAX_DISTANCE   (MAXD),
    .TIMEOUT_CYCLES (TMO),
    .CYCLE_PERIOD   (CP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .echo   (echo),
    .trig   (trig),
    .res    (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int prev_rise = -1;
  int hist[$];

  typedef struct {
    int delay;
    int len;
    int exp_raw;
    bit exp_oor;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int raw_of(input int len);
    int r;
    r = len / CPU;
    return (r > MAXD) ? MAXD : r;
  endfunction

  function automatic int model_dist(input int raw);
    int s;
    s = 0;
`ifdef ECHO2DIST_AVG_EN
    if (hist.size() == 0) begin
      repeat (4) hist.push_front(raw);
    end else begin
      hist.push_front(raw);
      void'(hist.pop_back());
    end
    foreach (hist[i]) s += hist[i];
    return s / 4;
`else
    s = raw;
    return s;
`endif
  endfunction

  // len > 0: echo pulse of len cycles after delay; len == 0: no echo;
  // len < 0: echo already high before the wait window opens.
  task automatic run_meas(input int delay, input int len, input int exp_raw,
                          input bit exp_oor, input string tag);
    int w;
    int hi;
    int k;
    int exp_d;
    w = 0;
    while (!trig && w < 2 * CP) begin
      step();
      w++;
    end
    check({tag, "_trig_seen"}, int'(trig), 1);
    if (prev_rise >= 0) check({tag, "_period"}, cyc - prev_rise, CP);
    prev_rise = cyc;
    if (len < 0) echo = 1'b1;
    hi = 0;
    w = 0;
    while (trig && w < 4 * TRIGC) begin
      hi++;
      step();
      w++;
    end
    check({tag, "_trig_len"}, hi, TRIGC);
    k = 0;
    if (len > 0) begin
      repeat (delay) step();
      echo = 1'b1;
      repeat (len) step();
      echo = 1'b0;
      while (k < 10) begin
        step();
        k++;
        if (bus.distance_valid) break;
      end
      check({tag, "_valid_lat"}, k, 3);
    end else begin
      while (k < TMO + 20) begin
        step();
        k++;
        if (bus.distance_valid) break;
      end
      check({tag, "_timeout_lat"}, k, TMO + 1);
    end
    exp_d = model_dist(exp_raw);
    check({tag, "_dist"}, int'(bus.distance), exp_d);
    check({tag, "_oor"}, int'(bus.out_of_range), int'(exp_oor));
    step();
    check({tag, "_valid_width"}, int'(bus.distance_valid), 0);
    check({tag, "_dist_hold"}, int'(bus.distance), exp_d);
    if (len < 0) echo = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    int cnt_v;
    int cnt_t;
    int d;
    int l;
    int r;

    tbl[0] = '{3,   50,  10, 1'b0};
    tbl[1] = '{0,    4,   0, 1'b0};
    tbl[2] = '{5,    5,   1, 1'b0};
    tbl[3] = '{1,    9,   1, 1'b0};
    tbl[4] = '{0,  499,  99, 1'b0};
    tbl[5] = '{2,  500, 100, 1'b1};
    tbl[6] = '{7,  520, 100, 1'b1};
    tbl[7] = '{0,    0, 100, 1'b1};
    tbl[8] = '{0,   -1, 100, 1'b1};

    reset  = 1'b1;
    enable = 1'b0;
    echo   = 1'b0;
    repeat (3) step();
    check("rst_trig", int'(trig), 0);
    check("rst_dist", int'(bus.distance), 0);
    check("rst_valid", int'(bus.distance_valid), 0);
    check("rst_oor", int'(bus.out_of_range), 0);
    enable = 1'b1;
    step();
    check("rst_trig_enabled", int'(trig), 0);
    reset = 1'b0;
    step();
    check("first_trig", int'(trig), 1);

    foreach (tbl[i]) begin
      run_meas(tbl[i].delay, tbl[i].len, tbl[i].exp_raw, tbl[i].exp_oor,
               $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(0, 100);
      l = $urandom_range(1, 560);
      r = raw_of(l);
      run_meas(d, l, r, r == MAXD, $sformatf("rnd%0d", i));
    end

    // enable dropped while the echo is being timed
    w = 0;
    while (!trig && w < 2 * CP) begin
      step();
      w++;
    end
    check("endrop_trig_seen", int'(trig), 1);
    w = 0;
    while (trig && w < 4 * TRIGC) begin
      step();
      w++;
    end
    echo = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    repeat (40) step();
    echo = 1'b0;
    k = 0;
    while (k < 10) begin
      step();
      k++;
      if (bus.distance_valid) break;
    end
    check("endrop_valid_lat", k, 3);
    check("endrop_dist", int'(bus.distance), model_dist(10));
    check("endrop_oor", int'(bus.out_of_range), 0);
    cnt_t = 0;
    repeat (CP + 200) begin
      step();
      if (trig) cnt_t++;
    end
    check("endrop_no_trig", cnt_t, 0);

    // reset asserted in the middle of a measurement
    enable = 1'b1;
    w = 0;
    while (!trig && w < 10) begin
      step();
      w++;
    end
    check("rstmid_trig_seen", int'(trig), 1);
    w = 0;
    while (trig && w < 4 * TRIGC) begin
      step();
      w++;
    end
    echo = 1'b1;
    repeat (20) step();
    reset = 1'b1;
    #1;
    check("rstmid_trig", int'(trig), 0);
    check("rstmid_dist", int'(bus.distance), 0);
    check("rstmid_valid", int'(bus.distance_valid), 0);
    check("rstmid_oor", int'(bus.out_of_range), 0);
    hist.delete();
    echo   = 1'b0;
    enable = 1'b0;
    cnt_v  = 0;
    repeat (5) begin
      step();
      if (bus.distance_valid) cnt_v++;
    end
    reset = 1'b0;
    cnt_t = 0;
    repeat (50) begin
      step();
      if (bus.distance_valid) cnt_v++;
      if (trig) cnt_t++;
    end
    check("rstmid_no_strobe", cnt_v, 0);
    check("rstmid_no_trig", cnt_t, 0);
    check("rstmid_dist_after", int'(bus.distance), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
